// File: rtl/hard_frame_feeder_pkg.sv
// Shared frame geometry and feeder FSM encoding for the hard-decision error-count path.
// Used by the feeder, its chunk buffer and the error-bit counter.
package hard_frame_feeder_pkg;

  localparam int VN_NUM        = 7650;
  localparam int N             = 850;
  localparam int ROW_CHUNK_NUM = VN_NUM / N;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    WAIT,
    REPORT
  } feeder_state_t;

endpackage

// File: rtl/hard_frame_feeder_chunk_buf.sv
// Frame chunk store: one write port and one async-read port, no reset on data.
// Write lands on the clock edge and is readable the following cycle; there is no backpressure.
module hard_chunk_buf
  import hard_frame_feeder_pkg::*;
#(
  parameter int DEPTH = ROW_CHUNK_NUM,
  parameter int W     = N,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_core_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_dat,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_dat
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_core_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/hard_frame_feeder.sv
// Buffers one frame of hard-decision chunks, streams them to the error counter and reports the count.
// First en one cycle after the last load; load_ready drops from STREAM until the result is acked.
module hard_frame_feeder
  import hard_frame_feeder_pkg::*;
#(
  parameter int VN_NUM           = hard_frame_feeder_pkg::VN_NUM,
  parameter int N                = hard_frame_feeder_pkg::N,
  parameter int ROW_CHUNK_NUM    = hard_frame_feeder_pkg::ROW_CHUNK_NUM,
  parameter int ERR_BIT_BITWIDTH = $clog2(VN_NUM),
  parameter int TIMEOUT_CYC      = 64
) (
  input  logic                        eval_clk,
  input  logic                        rstn,
  input  logic                        load_valid,
  input  logic [N-1:0]                load_data,
  output logic                        load_ready,
  input  logic                        flush,
  output logic [N-1:0]                hard_frame,
  output logic                        en,
  input  logic                        cnt_busy,
  input  logic                        count_done,
  input  logic [ERR_BIT_BITWIDTH-1:0] err_count,
  output logic                        result_valid,
  output logic [ERR_BIT_BITWIDTH-1:0] result_err,
  output logic                        result_pass,
  output logic                        result_timeout,
  input  logic                        result_ack
);

  localparam int PTR_W = (ROW_CHUNK_NUM > 1) ? $clog2(ROW_CHUNK_NUM) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ROW_CHUNK_NUM - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  feeder_state_t               r_state, w_state_nxt;
  logic [PTR_W-1:0]            r_wr_ptr, r_rd_ptr;
  logic [TO_W-1:0]             r_to_cnt;
  logic                        r_result_valid, r_result_timeout;
  logic [ERR_BIT_BITWIDTH-1:0] r_result_err;
  logic                        w_load_ready, w_xfer, w_en, w_rd_step;
  logic                        w_done_hit, w_to_hit, w_ack_hit;
  logic [N-1:0]                w_rd_dat;

  hard_chunk_buf #(
    .DEPTH (ROW_CHUNK_NUM),
    .W     (N),
    .AW    (PTR_W)
  ) u_chunk_buf (
    .i_core_clk (eval_clk),
    .i_wr_en    (w_xfer),
    .i_wr_addr  (r_wr_ptr),
    .i_wr_dat   (load_data),
    .i_rd_addr  (r_rd_ptr),
    .o_rd_dat   (w_rd_dat)
  );

  always_ff @(posedge eval_clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_ready = (r_state == IDLE) || (r_state == LOAD);
    w_xfer       = load_valid && w_load_ready && !flush;
    w_en         = 1'b0;
    w_rd_step    = 1'b0;
    w_done_hit   = 1'b0;
    w_to_hit     = 1'b0;
    w_ack_hit    = 1'b0;
    case (r_state)
      IDLE, LOAD: begin
        if (w_xfer) w_state_nxt = (r_wr_ptr == LAST_PTR) ? STREAM : LOAD;
      end
      STREAM: begin
        // A busy counter only stalls the frame before its first chunk goes out.
        w_en      = !((r_rd_ptr == '0) && cnt_busy);
        w_rd_step = w_en;
        if (w_en && (r_rd_ptr == LAST_PTR)) begin
          w_done_hit  = count_done;
          w_state_nxt = count_done ? REPORT : WAIT;
        end
      end
      WAIT: begin
        w_en = 1'b1;
        if (count_done) begin
          w_done_hit  = 1'b1;
          w_state_nxt = REPORT;
        end else if (r_to_cnt == TO_LAST) begin
          w_to_hit    = 1'b1;
          w_state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (result_ack) begin
          w_ack_hit   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_en        = 1'b0;
      w_rd_step   = 1'b0;
      w_done_hit  = 1'b0;
      w_to_hit    = 1'b0;
      w_ack_hit   = 1'b0;
    end
  end

  always_ff @(posedge eval_clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_to_cnt         <= '0;
      r_result_valid   <= 1'b0;
      r_result_err     <= '0;
      r_result_timeout <= 1'b0;
    end else if (flush) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_to_cnt         <= '0;
      r_result_valid   <= 1'b0;
      r_result_timeout <= 1'b0;
    end else begin
      if (w_xfer)    r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_rd_step) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      r_to_cnt <= ((r_state == WAIT) && (w_state_nxt == WAIT)) ? r_to_cnt + TO_W'(1) : '0;
      if (w_done_hit) begin
        r_result_err     <= err_count;
        r_result_valid   <= 1'b1;
        r_result_timeout <= 1'b0;
      end
      if (w_to_hit) begin
        r_result_err     <= '1;
        r_result_valid   <= 1'b1;
        r_result_timeout <= 1'b1;
      end
      if (w_ack_hit) begin
        r_result_valid   <= 1'b0;
        r_result_timeout <= 1'b0;
      end
    end
  end

  assign load_ready     = w_load_ready;
  assign en             = w_en;
  assign hard_frame     = ((r_state == STREAM) && w_en) ? w_rd_dat : '0;
  assign result_valid   = r_result_valid;
  assign result_err     = r_result_err;
  assign result_timeout = r_result_timeout;
  assign result_pass    = (r_result_err == '0) && !r_result_timeout;

endmodule

// File: tb/tb_hard_frame_feeder.sv
// Directed bench for hard_frame_feeder: vector table of whole frames plus flush and reset corner sequences.
module tb_hard_frame_feeder;

  localparam int N  = 850;
  localparam int CH = 9;
  localparam int EW = $clog2(7650);
  localparam int TO = 64;

  logic          eval_clk, rstn, load_valid, flush, cnt_busy, count_done, result_ack;
  logic [N-1:0]  load_data, hard_frame;
  logic          load_ready, en, result_valid, result_pass, result_timeout;
  logic [EW-1:0] err_count, result_err;

  int    n_chk  = 0;
  int    n_fail = 0;
  string tag    = "init";

  typedef struct {
    int          pat;
    int          busy;
    int          dly;      // -1 never, 0 in final STREAM cycle, k in k-th WAIT cycle
    int          err_in;
    logic [EW-1:0] exp_err;
    logic        exp_pass;
    logic        exp_to;
  } vec_t;

  vec_t vecs[5];

  hard_frame_feeder dut (
    .eval_clk       (eval_clk),
    .rstn           (rstn),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .flush          (flush),
    .hard_frame     (hard_frame),
    .en             (en),
    .cnt_busy       (cnt_busy),
    .count_done     (count_done),
    .err_count      (err_count),
    .result_valid   (result_valid),
    .result_err     (result_err),
    .result_pass    (result_pass),
    .result_timeout (result_timeout),
    .result_ack     (result_ack)
  );

  initial eval_clk = 1'b0;
  always #5 eval_clk = ~eval_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no completion, expected summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] chunk(input int pat, input int idx);
    logic [N-1:0] v;
    v = '0;
    case (pat)
      1: for (int b = 0; b < 10; b++) v[idx*20+b] = 1'b1;
      2: for (int b = 0; b < N; b++) v[b] = (((b * 7 + idx * 13) % 3) == 0);
      3: for (int b = 0; b < N; b++) v[b] = (((b + idx) % 5) == 1);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got %b expected %b", tag, nm, got, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0d expected %0d", tag, nm, got, exp);
    end
  endtask

  task automatic chkf(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got %h expected %h", tag, nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0d expected %0d", tag, nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge eval_clk);
    #1;
  endtask

  task automatic load_frame(input int pat, input int nchunks);
    for (int i = 0; i < nchunks; i++) begin
      load_valid = 1'b1;
      load_data  = chunk(pat, i);
      #4;
      chk1("load_ready", load_ready, 1'b1);
      chk1("en_during_load", en, 1'b0);
      step();
    end
    load_valid = 1'b0;
  endtask

  task automatic stream_frame(input int pat, input int busy, input bit done_last, input int err_in);
    int idx;
    int left;
    idx  = 0;
    left = busy;
    for (int c = 0; c < 40 && idx < CH; c++) begin
      cnt_busy   = (left > 0);
      count_done = done_last && (left == 0) && (idx == CH - 1);
      err_count  = EW'(err_in);
      #4;
      if (left > 0) begin
        chk1("en_hold", en, 1'b0);
        chkf("frame_hold", hard_frame, '0);
        left--;
      end else begin
        chk1("en_stream", en, 1'b1);
        chkf("frame_order", hard_frame, chunk(pat, idx));
        idx++;
      end
      step();
    end
    cnt_busy   = 1'b0;
    count_done = 1'b0;
    if (idx < CH) chki("stream_budget", idx, CH);
  endtask

  task automatic wait_phase(input int dly);
    int n_wait;
    n_wait = (dly < 0) ? TO : dly;
    for (int w = 1; w <= n_wait; w++) begin
      count_done = (w == dly);
      result_ack = (w == 1);
      #4;
      chk1("en_wait", en, 1'b1);
      chkf("frame_wait_zero", hard_frame, '0);
      chk1("valid_early", result_valid, 1'b0);
      step();
    end
    count_done = 1'b0;
    result_ack = 1'b0;
  endtask

  task automatic report_phase(input vec_t v);
    for (int k = 0; k < 3; k++) begin
      #4;
      chk1("valid_held", result_valid, 1'b1);
      chk1("en_report", en, 1'b0);
      chk1("ready_report", load_ready, 1'b0);
      chkw("result_err", result_err, v.exp_err);
      chk1("result_pass", result_pass, v.exp_pass);
      chk1("result_timeout", result_timeout, v.exp_to);
      step();
    end
    result_ack = 1'b1;
    #4;
    step();
    result_ack = 1'b0;
    #4;
    chk1("valid_cleared", result_valid, 1'b0);
    chk1("timeout_cleared", result_timeout, 1'b0);
    chk1("ready_after_ack", load_ready, 1'b1);
    chk1("en_after_ack", en, 1'b0);
    step();
  endtask

  task automatic run_vec(input vec_t v);
    load_frame(v.pat, CH);
    stream_frame(v.pat, v.busy, (v.dly == 0), v.err_in);
    if (v.dly != 0) wait_phase(v.dly);
    report_phase(v);
  endtask

  initial begin
    rstn       = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    flush      = 1'b0;
    cnt_busy   = 1'b0;
    count_done = 1'b0;
    err_count  = '0;
    result_ack = 1'b0;

    tag = "reset";
    repeat (2) @(posedge eval_clk);
    #1;
    #4;
    chk1("rst_en", en, 1'b0);
    chkf("rst_frame", hard_frame, '0);
    chk1("rst_valid", result_valid, 1'b0);
    chkw("rst_err", result_err, '0);
    chk1("rst_timeout", result_timeout, 1'b0);
    step();
    rstn = 1'b1;
    #4;
    chk1("ready_after_reset", load_ready, 1'b1);
    step();

    vecs[0] = '{1, 0,  3, 90, EW'(90), 1'b0, 1'b0};
    vecs[1] = '{0, 0,  1,  0, EW'(0),  1'b1, 1'b0};
    vecs[2] = '{1, 0, -1, 90, EW'(8191), 1'b0, 1'b1};
    vecs[3] = '{2, 5,  2, 17, EW'(17), 1'b0, 1'b0};
    vecs[4] = '{2, 0,  0,  5, EW'(5),  1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tag = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    // Flush part-way through a load, with a transfer offered in the same cycle.
    tag = "flush_load";
    load_frame(3, 5);
    load_valid = 1'b1;
    load_data  = chunk(3, 5);
    flush      = 1'b1;
    #4;
    chk1("en_flush", en, 1'b0);
    step();
    flush      = 1'b0;
    load_valid = 1'b0;
    #4;
    chk1("ready_after_flush", load_ready, 1'b1);
    chk1("en_after_flush", en, 1'b0);
    step();
    run_vec('{2, 0, 1, 12, EW'(12), 1'b0, 1'b0});

    // Flush racing count_done in WAIT must abort without a result.
    tag = "flush_done";
    load_frame(3, CH);
    stream_frame(3, 0, 1'b0, 33);
    flush      = 1'b1;
    count_done = 1'b1;
    err_count  = EW'(33);
    #4;
    chk1("en_flush_wait", en, 1'b0);
    step();
    flush      = 1'b0;
    count_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #4;
      chk1("valid_after_flush", result_valid, 1'b0);
      chk1("ready_idle", load_ready, 1'b1);
      chkw("err_kept", result_err, EW'(12));
      step();
    end

    // Reset asserted mid-STREAM.
    tag = "reset_stream";
    load_frame(1, CH);
    repeat (3) step();
    rstn       = 1'b0;
    count_done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #4;
      chk1("rst_en", en, 1'b0);
      chkf("rst_frame", hard_frame, '0);
      chk1("rst_valid", result_valid, 1'b0);
      chkw("rst_err", result_err, '0);
      chk1("rst_timeout", result_timeout, 1'b0);
      step();
    end
    rstn       = 1'b1;
    count_done = 1'b0;
    #4;
    chk1("ready_after_rst", load_ready, 1'b1);
    step();
    for (int k = 0; k < 4; k++) begin
      #4;
      chk1("no_valid_after_rst", result_valid, 1'b0);
      chk1("no_en_after_rst", en, 1'b0);
      step();
    end
    tag = "recover";
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hard_frame_feeder.md
HARD_FRAME_FEEDER -- requirements
Module: hard_frame_feeder

Interface
REQ-001 SHALL have parameter VN_NUM, default 7650: codeword length in variable nodes.
REQ-002 SHALL have parameter N, default 850: chunk width in bits.
REQ-003 SHALL have parameter ROW_CHUNK_NUM, default 9: chunks per frame, equal to VN_NUM/N.
REQ-004 SHALL have parameter ERR_BIT_BITWIDTH, default $clog2(VN_NUM): error-count width.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 64: maximum cycles to wait for count_done.
REQ-006 SHALL have port eval_clk, input, 1: the single clock.
REQ-007 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port load_valid, input, 1: decoder offers a hard-decision chunk.
REQ-009 SHALL have port load_data, input, N: hard-decision chunk, chunk 0 first.
REQ-010 SHALL have port load_ready, output, 1: feeder accepts the offered chunk.
REQ-011 SHALL have port flush, input, 1: synchronous abort.
REQ-012 SHALL have port hard_frame, output, N: chunk driven to the error-bit counter.
REQ-013 SHALL have port en, output, 1: counter enable.
REQ-014 SHALL have port cnt_busy, input, 1: counter busy.
REQ-015 SHALL have port count_done, input, 1: counter finished.
REQ-016 SHALL have port err_count, input, ERR_BIT_BITWIDTH: counter result.
REQ-017 SHALL have port result_valid, output, 1: result available to the decoder.
REQ-018 SHALL have port result_err, output, ERR_BIT_BITWIDTH: latched error count.
REQ-019 SHALL have port result_pass, output, 1: result_err equals 0.
REQ-020 SHALL have port result_timeout, output, 1: count_done did not arrive in time.
REQ-021 SHALL have port result_ack, input, 1: decoder consumes the result.

Function
REQ-022 SHALL implement an FSM with states IDLE, LOAD, STREAM, WAIT and REPORT.
REQ-023 load_ready SHALL be 1 only in IDLE and LOAD.
REQ-024 A transfer occurs when load_valid and load_ready are both high; it SHALL write load_data into buffer[wr_ptr] and increment wr_ptr; the first transfer moves IDLE to LOAD.
REQ-025 The transfer at wr_ptr equal to ROW_CHUNK_NUM-1 SHALL wrap wr_ptr to 0 and move the FSM to STREAM.
REQ-026 On entering STREAM with cnt_busy high, the FSM SHALL hold with en=0 until cnt_busy is low.
REQ-027 In STREAM, en SHALL be 1 and hard_frame SHALL be buffer[rd_ptr].
REQ-028 rd_ptr SHALL increment by one every cycle from 0 to ROW_CHUNK_NUM-1; after the last chunk the FSM SHALL move to WAIT.
REQ-029 In WAIT, en SHALL remain 1, hard_frame SHALL be all zeros, and a timeout counter SHALL increment each cycle.
REQ-030 count_done high in WAIT SHALL latch err_count into result_err, drop en the following cycle and move to REPORT.
REQ-031 If count_done is high in the final STREAM cycle, it SHALL be treated as arriving in WAIT (same latch, same transition).
REQ-032 When the timeout counter reaches TIMEOUT_CYC in WAIT, the FSM SHALL set result_timeout=1, set result_err to all ones and move to REPORT.
REQ-033 In REPORT, result_valid SHALL be held at 1 until result_ack is high (the decoder runs at half rate).
REQ-034 result_ack high in REPORT SHALL clear result_valid and result_timeout and return the FSM to IDLE in the same edge.
REQ-035 result_ack outside REPORT SHALL be ignored.
REQ-036 result_pass SHALL equal (result_err==0) && !result_timeout.
REQ-037 flush SHALL, in any state, zero wr_ptr, rd_ptr, the timeout counter and en, and return the FSM to IDLE next cycle; buffer contents need not be cleared.
REQ-038 flush SHALL take priority over load transfers and over count_done arriving in the same cycle.
REQ-039 Latency SHALL be 1 cycle from the last load transfer to the first en=1 cycle when cnt_busy is low.

Reset
REQ-040 While rstn is low, the FSM SHALL be IDLE and hard_frame, en, wr_ptr, rd_ptr, the timeout counter, result_valid, result_err and result_timeout SHALL be 0.
REQ-041 load_ready SHALL be 1 immediately after reset.
REQ-042 Reset SHALL abort any operation mid-frame with no result output.

Structure
REQ-043 A shared package SHALL hold the FSM state enum and the VN_NUM, N and ROW_CHUNK_NUM constants used by both the counter and the feeder.
REQ-044 The chunk buffer SHALL be a sub-module, hard_chunk_buf: ROW_CHUNK_NUM x N registers, one write port and one read port, no reset on data.

Verification
REQ-045 Load 9 chunks each 10 bits set; counter model returns err_count=90 -> en high exactly 9 STREAM cycles plus WAIT, result_err=90, result_pass=0, result_valid held until ack.
REQ-046 All-zero frame with err_count=0 -> result_pass=1, and result_ack returns the FSM to IDLE with load_ready=1 the next cycle.
REQ-047 Counter never asserts count_done -> result_timeout=1 after 64 WAIT cycles, result_err=8191.
REQ-048 cnt_busy high for 5 cycles when entering STREAM -> en stays 0 for those 5 cycles, then all 9 chunks streamed in order.
REQ-049 flush asserted after load chunk 4 -> FSM IDLE, wr_ptr 0; a fresh 9-chunk load then streams the new data only.
REQ-050 rstn pulled low during STREAM -> all outputs 0 while rstn is low, and no result_valid pulse.
